// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: register-file geometry and the GRF dumper state encoding.
package cpu_defs;

  localparam int NREG     = 32;
  localparam int AW       = 5;
  localparam int DW       = 32;
  localparam int LAST_REG = 31;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EMIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/grf_dumper.sv
// Walks GRF $1..$NREG-1 through a spare read port, one {PC, idx, value} record per 2 cycles.
// Records hold stable under OutReady low; Done pulses once after the last record.
module grf_dumper #(
  parameter int NREG      = cpu_defs::NREG,
  parameter int AW        = cpu_defs::AW,
  parameter int DW        = cpu_defs::DW,
  parameter bit SKIP_ZERO = 1'b0
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          Start,
  input  logic [31:0]   PC,
  output logic [AW-1:0] RA,
  input  logic [DW-1:0] RD,
  output logic          Busy,
  output logic          OutValid,
  input  logic          OutReady,
  output logic [AW-1:0] OutIdx,
  output logic [DW-1:0] OutData,
  output logic [31:0]   OutPC,
  output logic          Done
);
  import cpu_defs::state_e, cpu_defs::ST_IDLE, cpu_defs::ST_FETCH,
         cpu_defs::ST_EMIT, cpu_defs::ST_DONE;

  localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW-1:0] out_idx_q, out_idx_d;
  logic [DW-1:0] out_dat_q, out_dat_d;
  logic [31:0]   out_pc_q, out_pc_d;
  logic          skip_rd;
  logic          last_idx;

  assign skip_rd  = SKIP_ZERO && (RD == '0);
  assign last_idx = (idx_q == LAST_IDX);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      out_idx_q <= '0;
      out_dat_q <= '0;
      out_pc_q  <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      out_idx_q <= out_idx_d;
      out_dat_q <= out_dat_d;
      out_pc_q  <= out_pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (Start) state_d = ST_FETCH;
      ST_FETCH: begin
        if (!skip_rd)      state_d = ST_EMIT;
        else if (last_idx) state_d = ST_DONE;
      end
      ST_EMIT:  if (OutReady) state_d = last_idx ? ST_DONE : ST_FETCH;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // The record is latched at the FETCH edge, so a same-cycle GRF write is not seen.
  always_comb begin
    idx_d     = idx_q;
    out_idx_d = out_idx_q;
    out_dat_d = out_dat_q;
    out_pc_d  = out_pc_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          out_pc_d = PC;
          idx_d    = AW'(1);
        end
      end
      ST_FETCH: begin
        if (!skip_rd) begin
          out_dat_d = RD;
          out_idx_d = idx_q;
        end else if (!last_idx) begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_EMIT: begin
        if (OutReady && !last_idx) idx_d = idx_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    RA       = '0;
    Busy     = 1'b1;
    OutValid = 1'b0;
    Done     = 1'b0;
    case (state_q)
      ST_IDLE:  Busy     = 1'b0;
      ST_FETCH: RA       = idx_q;
      ST_EMIT:  OutValid = 1'b1;
      ST_DONE:  Done     = 1'b1;
      default: ;
    endcase
  end

  assign OutIdx  = out_idx_q;
  assign OutData = out_dat_q;
  assign OutPC   = out_pc_q;

endmodule

// File: tb/tb_grf_dumper.sv
// Directed and randomized dumps of a modelled GRF, checked against an expected record list
// and a cycle-count formula derived from the emit/skip/stall rules.
module tb_grf_dumper;

  logic        Clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_i;
  logic        start [2];
  logic        ordy  [2];
  logic [4:0]  ra    [2];
  logic [31:0] rd    [2];
  logic        busy  [2];
  logic        ovld  [2];
  logic        done  [2];
  logic [4:0]  oidx  [2];
  logic [31:0] odat  [2];
  logic [31:0] opc   [2];
  logic [31:0] grf   [32];

  int checks   = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  always_comb begin
    rd[0] = grf[ra[0]];
    rd[1] = grf[ra[1]];
  end

  grf_dumper #(.SKIP_ZERO(1'b0)) u_dut0 (
    .Clk(Clk), .Rst_n(rst_n), .Start(start[0]), .PC(pc_i), .RA(ra[0]), .RD(rd[0]),
    .Busy(busy[0]), .OutValid(ovld[0]), .OutReady(ordy[0]), .OutIdx(oidx[0]),
    .OutData(odat[0]), .OutPC(opc[0]), .Done(done[0])
  );

  grf_dumper #(.SKIP_ZERO(1'b1)) u_dut1 (
    .Clk(Clk), .Rst_n(rst_n), .Start(start[1]), .PC(pc_i), .RA(ra[1]), .RD(rd[1]),
    .Busy(busy[1]), .OutValid(ovld[1]), .OutReady(ordy[1]), .OutIdx(oidx[1]),
    .OutData(odat[1]), .OutPC(opc[1]), .Done(done[1])
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input int inst, input string tag);
    chk({tag, "_ra"},    64'(ra[inst]),   64'd0);
    chk({tag, "_busy"},  64'(busy[inst]), 64'd0);
    chk({tag, "_valid"}, 64'(ovld[inst]), 64'd0);
    chk({tag, "_idx"},   64'(oidx[inst]), 64'd0);
    chk({tag, "_data"},  64'(odat[inst]), 64'd0);
    chk({tag, "_pc"},    64'(opc[inst]),  64'd0);
    chk({tag, "_done"},  64'(done[inst]), 64'd0);
  endtask

  task automatic preload();
    grf[0] = 32'd0;
    for (int k = 1; k < 32; k++) grf[k] = 32'h1000_0000 + 32'(k);
  endtask

  // One dump on instance inst (1 = SKIP_ZERO). Expected records are a snapshot of grf at Start.
  task automatic dump(input int inst, input logic [31:0] pc, input bit rand_rdy,
                      input int stall_idx, input int stall_n, input int wr_idx,
                      input logic [31:0] wr_dat, input int restart_cyc, input int rst_idx);
    logic [36:0] exp_q[$];
    logic [36:0] head;
    int          cyc, stalls, nskip, nemit, hold_left;
    bit          got_done, rdy_v, wr_now;
    exp_q = {};
    for (int r = 1; r < 32; r++)
      if (!(inst == 1 && grf[r] == 32'd0)) exp_q.push_back({5'(r), grf[r]});
    nemit     = exp_q.size();
    nskip     = 31 - nemit;
    stalls    = 0;
    hold_left = stall_n;
    got_done  = 1'b0;
    @(negedge Clk);
    pc_i        = pc;
    start[inst] = 1'b1;
    @(negedge Clk);
    start[inst] = 1'b0;
    cyc = 1;
    chk("busy_rise", 64'(busy[inst]), 64'd1);
    while (!got_done && cyc < 400) begin
      rdy_v = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (ovld[inst]) begin
        if (exp_q.size() == 0) begin
          chk("record_overrun", 64'(exp_q.size()), 64'd1);
        end else begin
          head = exp_q[0];
          chk("rec_idx",  64'(oidx[inst]), 64'(head[36:32]));
          chk("rec_data", 64'(odat[inst]), 64'(head[31:0]));
          chk("rec_pc",   64'(opc[inst]),  64'(pc));
          if (rst_idx != 0 && int'(oidx[inst]) == rst_idx) begin
            rst_n = 1'b0;
            #1;
            chk_all_zero(inst, "rst_mid");
            @(negedge Clk);
            chk("rst_no_done", 64'(done[inst]), 64'd0);
            rst_n       = 1'b1;
            ordy[inst]  = 1'b1;
            repeat (2) begin
              @(negedge Clk);
              chk("rst_stay_idle", 64'({busy[inst], done[inst]}), 64'd0);
            end
            return;
          end
          if (int'(oidx[inst]) == stall_idx && hold_left > 0) begin
            rdy_v = 1'b0;
            hold_left--;
          end
          if (rdy_v) void'(exp_q.pop_front());
          else       stalls++;
        end
      end
      if (done[inst]) begin
        chk("done_cycle",   64'(cyc), 64'(2 * nemit + nskip + stalls + 1));
        chk("records_left", 64'(exp_q.size()), 64'd0);
        got_done = 1'b1;
      end
      wr_now      = (wr_idx != 0) && (ra[inst] == 5'(wr_idx));
      start[inst] = (cyc == restart_cyc);
      ordy[inst]  = rdy_v;
      if (wr_now) begin
        @(posedge Clk);
        grf[wr_idx] <= wr_dat;
      end
      @(negedge Clk);
      cyc++;
    end
    start[inst] = 1'b0;
    ordy[inst]  = 1'b1;
    chk("done_seen",  64'(got_done),   64'd1);
    chk("busy_fall",  64'(busy[inst]), 64'd0);
    chk("done_pulse", 64'(done[inst]), 64'd0);
    @(negedge Clk);
    chk("idle_after", 64'({busy[inst], done[inst]}), 64'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    pc_i     = 32'd0;
    start[0] = 1'b0;
    start[1] = 1'b0;
    ordy[0]  = 1'b1;
    ordy[1]  = 1'b1;
    for (int k = 0; k < 32; k++) grf[k] = 32'd0;
    #12;
    chk_all_zero(0, "reset");
    chk("reset_busy1", 64'(busy[1]), 64'd0);
    @(negedge Clk);
    rst_n = 1'b1;

    preload();
    dump(0, 32'h0000_3000, 1'b0, 0, 0, 0, 32'd0, 0, 0);
    dump(0, 32'h0000_3000, 1'b0, 5, 3, 0, 32'd0, 0, 0);

    for (int k = 0; k < 32; k++) grf[k] = 32'd0;
    grf[2]  = 32'hDEAD_BEEF;
    grf[31] = 32'h0000_0001;
    dump(1, 32'h0000_3000, 1'b0, 0, 0, 0, 32'd0, 0, 0);

    preload();
    grf[7] = 32'h0000_0007;
    dump(0, 32'h0000_3000, 1'b0, 0, 0, 7, 32'hAAAA_AAAA, 0, 0);

    preload();
    dump(0, 32'h0000_3000, 1'b0, 0, 0, 0, 32'd0, 20, 0);
    dump(0, 32'h0000_3000, 1'b0, 0, 0, 0, 32'd0, 0, 10);
    dump(0, 32'h0000_3000, 1'b0, 0, 0, 0, 32'd0, 0, 0);

    for (int it = 0; it < 4; it++) begin
      for (int k = 1; k < 32; k++)
        grf[k] = ($urandom_range(0, 2) == 0) ? 32'd0 : $urandom;
      dump(it % 2, $urandom, 1'b1, 0, 0, 0, 32'd0, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
